regfile_dump: RTL and testbench

Parametrised integer register file for the RISC-V single-cycle core, and the successor to the fixed 32×32 file. It keeps combinational dual read, load-width extension on write, store-width truncation on read port 2, the ecall-to-a0 redirect and the always-visible tube register. It adds XLEN/NREG parameters and write-to-read bypass. It also adds a debug dump engine that streams every register out over a valid/ready handshake, for the board UART/tube logger.

---
 rtl/regfile_dump.sv | 157 +++++++++++++++
 tb/tb_regfile_dump.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : regfile_dump
// Description : Parametrised RISC-V integer register file. Provides dual
//               combinational read, write bypass and load/store width shaping.
//               Includes a valid/ready dump engine that streams every register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int TUBE_IDX = NREG - 1,
  parameter  int A0_IDX   = 10,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [1:0]      rd2_size,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [1:0]      wr_size,
  input  logic            wr_unsigned,
  input  logic            ecall,
  output logic [XLEN-1:0] tube_data,
  input  logic            dump_req,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_busy,
  output logic            dump_done
);

  localparam logic [AW-1:0] c_A0_IDX = AW'(A0_IDX);
  localparam logic [AW-1:0] c_LAST   = AW'(NREG - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  logic [XLEN-1:0] r_regs [NREG];
  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_nxt;
  logic            r_done;
  logic            w_done_nxt;

  logic [AW-1:0]   w_ea;
  logic [XLEN-1:0] w_ext;
  logic            w_we;
  logic            w_sx8;
  logic            w_sx16;
  logic [XLEN-1:0] w_rs2_base;

  // Write-side address redirect and load-width extension
  always_comb begin
    w_ea   = ecall ? c_A0_IDX : wr_addr;
    w_we   = wr_en && (w_ea != '0);
    w_sx8  = ~wr_unsigned & wr_data[7];
    w_sx16 = ~wr_unsigned & wr_data[15];
    case (wr_size)
      2'b00:   w_ext = {{(XLEN-8){w_sx8}}, wr_data[7:0]};
      2'b01:   w_ext = {{(XLEN-16){w_sx16}}, wr_data[15:0]};
      default: w_ext = wr_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[w_ea] <= w_ext;
    end
  end

  // Bypass only fires for a nonzero address, so a write to x0 never leaks through
  always_comb begin
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (wr_en && (w_ea == rs1_addr))
      rs1_data = w_ext;
    else
      rs1_data = r_regs[rs1_addr];
  end

  always_comb begin
    if (rs2_addr == '0)
      w_rs2_base = '0;
    else if (wr_en && (w_ea == rs2_addr))
      w_rs2_base = w_ext;
    else
      w_rs2_base = r_regs[rs2_addr];
    case (rd2_size)
      2'b00:   rs2_data = {{(XLEN-8){w_rs2_base[7]}}, w_rs2_base[7:0]};
      2'b01:   rs2_data = {{(XLEN-16){w_rs2_base[15]}}, w_rs2_base[15:0]};
      default: rs2_data = w_rs2_base;
    endcase
  end

  assign tube_data = r_regs[TUBE_IDX];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    dump_valid  = 1'b0;
    dump_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dump_req) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (r_idx == c_LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + AW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beat data reads the array directly so a stalled beat picks up core writes
  assign dump_idx  = r_idx;
  assign dump_data = (r_state == S_SEND) ? r_regs[r_idx] : '0;
  assign dump_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`timescale 1ns/1ps
`default_nettype none
// Directed self-checking bench for regfile_dump: reset, load/store width,
// bypass, ecall redirect, tube mirror and the dump engine.
module tb_regfile_dump;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [1:0]      rd2_size;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [1:0]      wr_size;
  logic            wr_unsigned;
  logic            ecall;
  logic [XLEN-1:0] tube_data;
  logic            dump_req, dump_valid, dump_ready;
  logic [AW-1:0]   dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            dump_busy, dump_done;

  int total = 0;
  int bad   = 0;

  regfile_dump #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd2_size(rd2_size),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
    .wr_unsigned(wr_unsigned), .ecall(ecall), .tube_data(tube_data),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  // Stimulus only: one write cycle, returns on the following negedge
  task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                           input logic [1:0] sz, input logic uns, input logic ec);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_size = sz; wr_unsigned = uns; ecall = ec;
    @(negedge clk);
    wr_en = 1'b0; ecall = 1'b0; wr_unsigned = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL reset_rs1: got %h want %h", rs1_data, 32'h0); end
    total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL reset_rs2: got %h want %h", rs2_data, 32'h0); end
    total++; if (tube_data !== 32'h0) begin bad++; $display("FAIL reset_tube: got %h want %h", tube_data, 32'h0); end
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dump_valid); end
    total++; if (dump_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", dump_busy); end
    total++; if (dump_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", dump_done); end
    total++; if (dump_idx !== 5'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", dump_idx); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_middump();
    write_reg(5'd5, 32'h1234_5678, 2'b10, 1'b0, 1'b0);
    rs1_addr = 5'd5; rd2_size = 2'b10;
    #1;
    total++; if (rs1_data !== 32'h1234_5678) begin bad++; $display("FAIL md_x5: got %h want %h", rs1_data, 32'h1234_5678); end
    @(negedge clk);
    dump_req = 1'b1; dump_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (dump_valid !== 1'b1) begin bad++; $display("FAIL md_valid_rise: got %b want 1", dump_valid); end
    @(negedge clk);
    dump_req = 1'b0; dump_ready = 1'b1;
    repeat (3) @(negedge clk);
    dump_ready = 1'b0;
    #1;
    total++; if (dump_idx !== 5'd3) begin bad++; $display("FAIL md_idx3: got %0d want 3", dump_idx); end
    #2 reset = 1'b0;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL md_rst_rs1: got %h want %h", rs1_data, 32'h0); end
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL md_rst_valid: got %b want 0", dump_valid); end
    total++; if (dump_busy !== 1'b0) begin bad++; $display("FAIL md_rst_busy: got %b want 0", dump_busy); end
    total++; if (dump_idx !== 5'd0) begin bad++; $display("FAIL md_rst_idx: got %0d want 0", dump_idx); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL md_post_valid: got %b want 0", dump_valid); end
  endtask

  task automatic test_load_ext();
    rs1_addr = 5'd6;
    write_reg(5'd6, 32'h0000_0080, 2'b00, 1'b0, 1'b0); #1;
    total++; if (rs1_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL ext_byte_s: got %h want %h", rs1_data, 32'hFFFF_FF80); end
    write_reg(5'd6, 32'h0000_0080, 2'b00, 1'b1, 1'b0); #1;
    total++; if (rs1_data !== 32'h0000_0080) begin bad++; $display("FAIL ext_byte_u: got %h want %h", rs1_data, 32'h0000_0080); end
    write_reg(5'd6, 32'h0001_8000, 2'b01, 1'b0, 1'b0); #1;
    total++; if (rs1_data !== 32'hFFFF_8000) begin bad++; $display("FAIL ext_half_s: got %h want %h", rs1_data, 32'hFFFF_8000); end
    write_reg(5'd6, 32'h0001_8000, 2'b01, 1'b1, 1'b0); #1;
    total++; if (rs1_data !== 32'h0000_8000) begin bad++; $display("FAIL ext_half_u: got %h want %h", rs1_data, 32'h0000_8000); end
    write_reg(5'd6, 32'h8001_8000, 2'b11, 1'b1, 1'b0); #1;
    total++; if (rs1_data !== 32'h8001_8000) begin bad++; $display("FAIL ext_full: got %h want %h", rs1_data, 32'h8001_8000); end
  endtask

  task automatic test_bypass_x0();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; wr_size = 2'b10; ecall = 1'b0;
    rs1_addr = 5'd7; rs2_addr = 5'd7; rd2_size = 2'b10;
    #1;
    total++; if (rs1_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL byp_rs1: got %h want %h", rs1_data, 32'hA5A5_A5A5); end
    total++; if (rs2_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL byp_rs2: got %h want %h", rs2_data, 32'hA5A5_A5A5); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    total++; if (rs1_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL byp_array: got %h want %h", rs1_data, 32'hA5A5_A5A5); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL x0_byp_rs1: got %h want %h", rs1_data, 32'h0); end
    total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL x0_byp_rs2: got %h want %h", rs2_data, 32'h0); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL x0_array: got %h want %h", rs1_data, 32'h0); end
  endtask

  task automatic test_ecall_store();
    write_reg(5'd3, 32'h0000_0033, 2'b10, 1'b0, 1'b0);
    write_reg(5'd3, 32'h0000_0042, 2'b10, 1'b0, 1'b1);
    rs1_addr = 5'd10; rs2_addr = 5'd3; rd2_size = 2'b10;
    #1;
    total++; if (rs1_data !== 32'h0000_0042) begin bad++; $display("FAIL ecall_a0: got %h want %h", rs1_data, 32'h42); end
    total++; if (rs2_data !== 32'h0000_0033) begin bad++; $display("FAIL ecall_x3: got %h want %h", rs2_data, 32'h33); end
    write_reg(5'd4, 32'h0000_01FF, 2'b10, 1'b0, 1'b0);
    rs2_addr = 5'd4; rd2_size = 2'b00;
    #1;
    total++; if (rs2_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL st_byte: got %h want %h", rs2_data, 32'hFFFF_FFFF); end
    rd2_size = 2'b01;
    #1;
    total++; if (rs2_data !== 32'h0000_01FF) begin bad++; $display("FAIL st_half: got %h want %h", rs2_data, 32'h1FF); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0000_0099; wr_size = 2'b10;
    #1;
    total++; if (tube_data !== 32'h0) begin bad++; $display("FAIL tube_nobyp: got %h want %h", tube_data, 32'h0); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    total++; if (tube_data !== 32'h0000_0099) begin bad++; $display("FAIL tube: got %h want %h", tube_data, 32'h99); end
  endtask

  task automatic test_dump_backpressure();
    int beats;
    int dones;
    beats = 0; dones = 0;
    for (int i = 1; i < NREG; i++) write_reg(AW'(i), XLEN'(i * 17), 2'b10, 1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      dump_req   = (c == 0) || (c == 20);
      dump_ready = (c % 2 == 1);
      #1;
      if (dump_valid && dump_ready) begin
        total++; if (dump_idx !== AW'(beats)) begin bad++; $display("FAIL bp_idx: got %0d want %0d", dump_idx, beats); end
        total++; if (dump_data !== XLEN'(beats * 17)) begin bad++; $display("FAIL bp_data: got %h want %h", dump_data, beats * 17); end
        beats++;
      end
      if (dump_done) begin
        dones++;
        total++; if (dump_busy !== 1'b0) begin bad++; $display("FAIL bp_done_busy: got %b want 0", dump_busy); end
      end
    end
    dump_req = 1'b0; dump_ready = 1'b0;
    total++; if (beats != 32) begin bad++; $display("FAIL bp_beats: got %0d want 32", beats); end
    total++; if (dones != 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", dones); end
    total++; if (dump_busy !== 1'b0) begin bad++; $display("FAIL bp_end_busy: got %b want 0", dump_busy); end
  endtask

  task automatic test_write_stall();
    bit got_done;
    got_done = 1'b0;
    @(negedge clk);
    dump_req = 1'b1; dump_ready = 1'b0;
    @(negedge clk);
    dump_req = 1'b0; dump_ready = 1'b1;
    repeat (9) @(negedge clk);
    dump_ready = 1'b0;
    #1;
    total++; if (dump_idx !== 5'd9) begin bad++; $display("FAIL ws_idx: got %0d want 9", dump_idx); end
    total++; if (dump_data !== 32'h0000_0099) begin bad++; $display("FAIL ws_old: got %h want %h", dump_data, 32'h99); end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEAD_BEEF; wr_size = 2'b10; ecall = 1'b0;
    #1;
    total++; if (dump_data !== 32'h0000_0099) begin bad++; $display("FAIL ws_nobyp: got %h want %h", dump_data, 32'h99); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    total++; if (dump_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ws_new: got %h want %h", dump_data, 32'hDEAD_BEEF); end
    total++; if (dump_idx !== 5'd9) begin bad++; $display("FAIL ws_hold_idx: got %0d want 9", dump_idx); end
    total++; if (dump_valid !== 1'b1) begin bad++; $display("FAIL ws_hold_valid: got %b want 1", dump_valid); end
    dump_ready = 1'b1;
    for (int c = 0; c < 64 && !got_done; c++) begin
      @(negedge clk); #1;
      if (dump_done) got_done = 1'b1;
    end
    dump_ready = 1'b0;
    total++; if (got_done !== 1'b1) begin bad++; $display("FAIL ws_done: got %b want 1", got_done); end
  endtask

  initial begin
    reset = 1'b0;
    rs1_addr = 5'd5; rs2_addr = 5'd5; rd2_size = 2'b10;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_size = 2'b10; wr_unsigned = 1'b0; ecall = 1'b0;
    dump_req = 1'b0; dump_ready = 1'b0;
    test_reset();
    test_reset_middump();
    test_load_ext();
    test_bypass_x0();
    test_ecall_store();
    test_dump_backpressure();
    test_write_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
